// File: rtl/ram_loader_pkg.sv
// Shared types and default geometry for the search-RAM fill controller.
package ram_loader_pkg;

   localparam int unsigned DATA_W_DEF = 3;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DEPTH_DEF  = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_PAD  = 2'b10,
      S_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/ram_loader_ptr.sv
// RAM address pointer shared by the LOAD and PAD phases.
// Holds at the terminal address rather than wrapping to 0.
module ram_loader_ptr
   import ram_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   assign last = (ptr == PTR_LAST);

   // Pointer register: clear on a new session, step on each write.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ptr <= '0;
      end else if (inc && !last) begin
         ptr <= ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/ram_loader.sv
// Sequential fill controller for the single-port search RAM.
// Streams words into addresses 0..DEPTH-1, pads the remainder with
// FILL_VAL, then signals completion to the search datapath.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int unsigned             DATA_W   = DATA_W_DEF,
   parameter int unsigned             ADDR_W   = ADDR_W_DEF,
   parameter int unsigned             DEPTH    = DEPTH_DEF,
   parameter logic [DATA_W-1:0]       FILL_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   ptr;
   logic                ptr_last;
   logic                ptr_clear;
   logic                ptr_inc;
   logic                beat;
   logic                wr_en;
   logic [DATA_W-1:0]   wr_data;

   ram_loader_ptr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ptr (
      .clk   (clk),
      .reset (reset),
      .clear (ptr_clear),
      .inc   (ptr_inc),
      .ptr   (ptr),
      .last  (ptr_last)
   );

   assign in_ready = (state == S_LOAD);
   assign busy     = (state == S_LOAD) || (state == S_PAD);
   assign ram_ce   = ram_we;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and the write request for this cycle.
   always_comb begin
      state_next = state;
      ptr_clear  = 1'b0;
      ptr_inc    = 1'b0;
      beat       = 1'b0;
      wr_en      = 1'b0;
      wr_data    = FILL_VAL;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_LOAD;
               ptr_clear  = 1'b1;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               beat    = 1'b1;
               wr_en   = 1'b1;
               wr_data = in_data;
               ptr_inc = 1'b1;
               if (ptr_last) begin
                  state_next = S_DONE;
               end else if (in_last) begin
                  state_next = S_PAD;
               end
            end
         end
         S_PAD: begin
            wr_en   = 1'b1;
            ptr_inc = 1'b1;
            if (ptr_last) begin
               state_next = S_DONE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Registered RAM port plus session status. done trails the DONE
   // state by one cycle so it rises only after the final write is
   // presented, and drops together with the restart.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         done     <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         ram_we   <= wr_en;
         ram_addr <= wr_en ? ptr : '0;
         ram_data <= wr_en ? wr_data : '0;
         done     <= (state == S_DONE) && !start;
         if (ptr_clear) begin
            count    <= '0;
            overflow <= 1'b0;
         end else if (beat) begin
            if (count != CNT_MAX) begin
               count <= count + CNT_ONE;
            end
            if (ptr_last && !in_last) begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader.
module tb_ram_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_data;
   logic       in_last;
   logic       ram_ce;
   logic       ram_we;
   logic [4:0] ram_addr;
   logic [2:0] ram_data;
   logic       busy;
   logic       done;
   logic [5:0] count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   logic [19:0] all_out;
   logic [9:0]  wr_obs;
   logic [9:0]  wr_exp;

   assign all_out = {in_ready, ram_ce, ram_we, ram_addr, ram_data, busy, done, count, overflow};
   assign wr_obs  = {ram_ce, ram_we, ram_addr, ram_data};

   always #5 clk = ~clk;

   ram_loader #(
      .DATA_W   (3),
      .ADDR_W   (5),
      .DEPTH    (32),
      .FILL_VAL (3'b000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .ram_ce   (ram_ce),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 3'd0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++;
      if (all_out !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected %h", all_out, 20'd0);
      end
      reset = 1'b0;
   endtask

   task automatic test_idle_valid;
      in_valid = 1'b1;
      in_data  = 3'd5;
      in_last  = 1'b1;
      tick();
      tick();
      checks++;
      if (all_out !== 20'd0) begin
         errors++;
         $display("FAIL idle_valid_ignored got %h expected %h", all_out, 20'd0);
      end
      idle_inputs();
   endtask

   task automatic test_full_load;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL full_ready_after_start got %b expected %b", {in_ready, busy}, 2'b11);
      end
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data  = 3'(i % 8);
         in_last  = (i == 31);
         tick();
         wr_exp = {1'b1, 1'b1, 5'(i), 3'(i % 8)};
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL full_write[%0d] got %h expected %h", i, wr_obs, wr_exp);
         end
      end
      idle_inputs();
      checks++;
      if ({done, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL full_done_cycle33 got %b expected %b", {done, in_ready}, 2'b00);
      end
      tick();
      checks++;
      if ({done, busy, ram_we, overflow, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd32}) begin
         errors++;
         $display("FAIL full_done_cycle34 got %h expected %h",
                  {done, busy, ram_we, overflow, count}, {1'b1, 1'b0, 1'b0, 1'b0, 6'd32});
      end
   endtask

   task automatic test_restart_pad;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({done, in_ready, count} !== {1'b0, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL restart_clear got %h expected %h", {done, in_ready, count}, {1'b0, 1'b1, 6'd0});
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 3'(i + 1);
         in_last  = (i == 4);
         tick();
         wr_exp = {1'b1, 1'b1, 5'(i), 3'(i + 1)};
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL short_write[%0d] got %h expected %h", i, wr_obs, wr_exp);
         end
      end
      idle_inputs();
      checks++;
      if ({in_ready, busy, count} !== {1'b0, 1'b1, 6'd5}) begin
         errors++;
         $display("FAIL pad_entry got %h expected %h", {in_ready, busy, count}, {1'b0, 1'b1, 6'd5});
      end
      for (int a = 5; a < 32; a++) begin
         tick();
         wr_exp = {1'b1, 1'b1, 5'(a), 3'd0};
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL pad_write[%0d] got %h expected %h", a, wr_obs, wr_exp);
         end
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL pad_done_early got %b expected %b", done, 1'b0);
      end
      tick();
      checks++;
      if ({done, ram_we, count, overflow} !== {1'b1, 1'b0, 6'd5, 1'b0}) begin
         errors++;
         $display("FAIL pad_done got %h expected %h", {done, ram_we, count, overflow}, {1'b1, 1'b0, 6'd5, 1'b0});
      end
   endtask

   task automatic test_overflow;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data  = 3'(7 - (i % 8));
         in_last  = 1'b0;
         tick();
         wr_exp = {1'b1, 1'b1, 5'(i), 3'(7 - (i % 8))};
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL ovf_write[%0d] got %h expected %h", i, wr_obs, wr_exp);
         end
      end
      in_valid = 1'b1;
      in_data  = 3'd6;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ovf_extra_ready got %b expected %b", in_ready, 1'b0);
      end
      tick();
      checks++;
      if ({done, overflow, ram_we, count} !== {1'b1, 1'b1, 1'b0, 6'd32}) begin
         errors++;
         $display("FAIL ovf_status got %h expected %h", {done, overflow, ram_we, count}, {1'b1, 1'b1, 1'b0, 6'd32});
      end
      tick();
      checks++;
      if ({ram_we, count, in_ready} !== {1'b0, 6'd32, 1'b0}) begin
         errors++;
         $display("FAIL ovf_extra_beat got %h expected %h", {ram_we, count, in_ready}, {1'b0, 6'd32, 1'b0});
      end
      idle_inputs();
   endtask

   task automatic test_bubbles;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k % 2 == 0);
         in_data  = 3'(k / 2 + 4);
         in_last  = 1'b0;
         tick();
         if (k % 2 == 0) wr_exp = {1'b1, 1'b1, 5'(k / 2), 3'(k / 2 + 4)};
         else            wr_exp = 10'd0;
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL bubble_cycle[%0d] got %h expected %h", k, wr_obs, wr_exp);
         end
      end
      idle_inputs();
      checks++;
      if (count !== 6'd4) begin
         errors++;
         $display("FAIL bubble_count got %0d expected %0d", count, 4);
      end
      // start during LOAD must not rewind the pointer
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 3'd2;
      tick();
      idle_inputs();
      checks++;
      if ({wr_obs, count} !== {1'b1, 1'b1, 5'd4, 3'd2, 6'd5}) begin
         errors++;
         $display("FAIL start_in_load got %h expected %h", {wr_obs, count}, {1'b1, 1'b1, 5'd4, 3'd2, 6'd5});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset_mid;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 3'(i);
         in_last  = 1'b0;
         tick();
      end
      wr_exp = {1'b1, 1'b1, 5'd9, 3'd1};
      checks++;
      if (wr_obs !== wr_exp) begin
         errors++;
         $display("FAIL mid_beat10 got %h expected %h", wr_obs, wr_exp);
      end
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 3'd7;
      tick();
      checks++;
      if (all_out !== 20'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %h expected %h", all_out, 20'd0);
      end
      reset = 1'b0;
      idle_inputs();
      tick();
      checks++;
      if (all_out !== 20'd0) begin
         errors++;
         $display("FAIL mid_reset_idle got %h expected %h", all_out, 20'd0);
      end
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 3'd3;
      in_last  = 1'b1;
      tick();
      idle_inputs();
      wr_exp = {1'b1, 1'b1, 5'd0, 3'd3};
      checks++;
      if (wr_obs !== wr_exp) begin
         errors++;
         $display("FAIL post_reset_write0 got %h expected %h", wr_obs, wr_exp);
      end
      for (int a = 1; a < 32; a++) begin
         tick();
         wr_exp = {1'b1, 1'b1, 5'(a), 3'd0};
         checks++;
         if (wr_obs !== wr_exp) begin
            errors++;
            $display("FAIL post_reset_pad[%0d] got %h expected %h", a, wr_obs, wr_exp);
         end
      end
      tick();
      checks++;
      if ({done, count, overflow} !== {1'b1, 6'd1, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_done got %h expected %h", {done, count, overflow}, {1'b1, 6'd1, 1'b0});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_idle_valid();
      test_full_load();
      test_restart_pad();
      test_overflow();
      test_bubbles();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
